// File: rtl/display_if.sv
// Handshake and result bus between a requester and the binary-to-BCD display converter.
interface display_if;
    logic       start;
    logic [7:0] value;
    logic       busy;
    logic       done;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic       neg;
    logic       blank_tens;
    logic       blank_hund;

    modport master (
        output start, value,
        input  busy, done, ones, tens, hundreds, neg, blank_tens, blank_hund
    );

    modport slave (
        input  start, value,
        output busy, done, ones, tens, hundreds, neg, blank_tens, blank_hund
    );
endinterface

// File: rtl/display_ctrl.sv
// Converts an 8-bit calculator result (signed or unsigned) to sign + three BCD digits
// using a sequential double-dabble over 8 shift cycles, with leading-zero blank flags.
module display_ctrl #(
    parameter int unsigned SIGNED_MODE = 1
) (
    input  logic     clk,
    input  logic     rst,
    display_if.slave dbus
);
    localparam int unsigned DW = 8;
    localparam int unsigned BW = 4;
    localparam int unsigned SW = 3 * BW;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] scratch;
    logic [DW-1:0] mag;
    logic          sign;
    logic [SW-1:0] adj_c;
    logic          neg_in_c;

    function automatic logic [BW-1:0] dab(input logic [BW-1:0] d);
        return (d >= BW'(5)) ? d + BW'(3) : d;
    endfunction

    // Add-3 correction applied to every scratch digit before the shift
    always_comb begin
        adj_c    = {dab(scratch[11:8]), dab(scratch[7:4]), dab(scratch[3:0])};
        neg_in_c = (SIGNED_MODE != 0) && dbus.value[DW-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            scratch         <= '0;
            mag             <= '0;
            sign            <= 1'b0;
            dbus.busy       <= 1'b0;
            dbus.done       <= 1'b0;
            dbus.ones       <= '0;
            dbus.tens       <= '0;
            dbus.hundreds   <= '0;
            dbus.neg        <= 1'b0;
            dbus.blank_tens <= 1'b1;
            dbus.blank_hund <= 1'b1;
        end else begin
            dbus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dbus.start) begin
                        // The 9-bit magnitude never exceeds 255 (0x80 -> 128), so its
                        // MSB is always zero and an 8-bit negate gives the same bits.
                        mag       <= neg_in_c ? DW'(DW'(0) - dbus.value) : dbus.value;
                        scratch   <= '0;
                        cnt       <= '0;
                        sign      <= neg_in_c;
                        dbus.busy <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, mag} <= {adj_c, mag} << 1;
                    cnt            <= cnt + CW'(1);
                    if (cnt == CW'(7)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    dbus.ones       <= scratch[3:0];
                    dbus.tens       <= scratch[7:4];
                    dbus.hundreds   <= scratch[11:8];
                    dbus.neg        <= sign;
                    dbus.blank_hund <= (scratch[11:8] == BW'(0));
                    dbus.blank_tens <= (scratch[11:8] == BW'(0)) && (scratch[7:4] == BW'(0));
                    dbus.done       <= 1'b1;
                    dbus.busy       <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_display_ctrl.sv
// Directed bench for display_ctrl: signed and unsigned instances, expected digits queued
// at start and compared when done pulses.
module tb_display_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_if bus_s();
    display_if bus_u();

    display_ctrl #(.SIGNED_MODE(1)) dut_s (.clk(clk), .rst(rst), .dbus(bus_s.slave));
    display_ctrl #(.SIGNED_MODE(0)) dut_u (.clk(clk), .rst(rst), .dbus(bus_u.slave));

    typedef struct packed {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic       n;
        logic       bt;
        logic       bh;
    } exp_t;

    exp_t q_s[$];
    exp_t q_u[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt_s = 0;
    int   done_cnt_u = 0;
    int   last_done_s = 0;
    int   prev_done_s = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer divide of |value|, independent of the shift-add algorithm
    function automatic exp_t model(input bit sm, input logic [7:0] v);
        int   m;
        exp_t e;
        m    = (sm && v[7]) ? 256 - int'(v) : int'(v);
        e.h  = 4'(m / 100);
        e.t  = 4'((m / 10) % 10);
        e.o  = 4'(m % 10);
        e.n  = sm && v[7];
        e.bh = (e.h == 4'd0);
        e.bt = e.bh && (e.t == 4'd0);
        return e;
    endfunction

    function automatic logic [14:0] outs(input bit sm);
        if (sm) return {bus_s.hundreds, bus_s.tens, bus_s.ones, bus_s.neg, bus_s.blank_tens, bus_s.blank_hund};
        return {bus_u.hundreds, bus_u.tens, bus_u.ones, bus_u.neg, bus_u.blank_tens, bus_u.blank_hund};
    endfunction

    function automatic logic [1:0] flags(input bit sm);
        return sm ? {bus_s.busy, bus_s.done} : {bus_u.busy, bus_u.done};
    endfunction

    task automatic drive(input bit sm, input logic st, input logic [7:0] v);
        if (sm) begin
            bus_s.start = st;
            bus_s.value = v;
        end else begin
            bus_u.start = st;
            bus_u.value = v;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every done pulse must consume exactly one queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (bus_s.done) begin
            done_cnt_s++;
            prev_done_s = last_done_s;
            last_done_s = cyc;
            chk("done_s with pending result", 32'(q_s.size() != 0), 32'd1);
            if (q_s.size() != 0) begin
                e = q_s.pop_front();
                chk("result_s", 32'(outs(1'b1)), 32'(e));
            end
        end
        if (bus_u.done) begin
            done_cnt_u++;
            chk("done_u with pending result", 32'(q_u.size() != 0), 32'd1);
            if (q_u.size() != 0) begin
                e = q_u.pop_front();
                chk("result_u", 32'(outs(1'b0)), 32'(e));
            end
        end
    end

    // One conversion: checks latency, busy and output hold while shifting
    task automatic conv(input bit sm, input logic [7:0] v);
        logic [14:0] prev;
        int          n;
        prev = outs(sm);
        drive(sm, 1'b1, v);
        if (sm) q_s.push_back(model(1'b1, v));
        else    q_u.push_back(model(1'b0, v));
        @(posedge clk);
        #1 drive(sm, 1'b0, 8'($urandom));
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (flags(sm)[0]) break;
            chk("busy during conversion", 32'(flags(sm)[1]), 32'd1);
            chk("outputs held during shift", 32'(outs(sm)), 32'(prev));
        end
        chk("done latency", 32'(n), 32'd9);
        chk("busy after done", 32'(flags(sm)[1]), 32'd0);
    endtask

    initial begin
        int base;
        int k;
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset state s", 32'({flags(1'b1), outs(1'b1)}), 32'({2'b00, 12'h000, 3'b011}));
        chk("reset state u", 32'({flags(1'b0), outs(1'b0)}), 32'({2'b00, 12'h000, 3'b011}));
        rst = 1'b0;
        @(negedge clk);

        conv(1'b1, 8'h07);
        conv(1'b1, 8'h9C);
        conv(1'b1, 8'h80);
        conv(1'b1, 8'hFF);
        conv(1'b0, 8'hFF);
        conv(1'b0, 8'h0A);
        conv(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            conv(1'b1, 8'($urandom));
            conv(1'b0, 8'($urandom));
        end

        // Start while busy is dropped, not queued
        base = done_cnt_s;
        drive(1'b1, 1'b1, 8'h2A);
        q_s.push_back(model(1'b1, 8'h2A));
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1 drive(1'b1, 1'b1, 8'h63);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 8'h00);
        repeat (25) @(negedge clk);
        chk("single done for ignored start", 32'(done_cnt_s - base), 32'd1);

        // Start held high: DONE cycle ignores it, IDLE re-accepts -> 10-cycle period
        base = done_cnt_s;
        drive(1'b1, 1'b1, 8'h11);
        q_s.push_back(model(1'b1, 8'h11));
        @(posedge clk);
        #1 drive(1'b1, 1'b1, 8'h22);
        q_s.push_back(model(1'b1, 8'h22));
        repeat (10) @(posedge clk);
        #1 drive(1'b1, 1'b0, 8'h00);
        k = 0;
        while ((done_cnt_s - base) < 2 && k < 40) begin
            @(negedge clk);
            k++;
        end
        repeat (12) @(negedge clk);
        chk("back-to-back done count", 32'(done_cnt_s - base), 32'd2);
        chk("back-to-back period", 32'(last_done_s - prev_done_s), 32'd10);

        // Reset at shift count 4 aborts with no done pulse
        base = done_cnt_s;
        drive(1'b1, 1'b1, 8'h63);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 8'h00);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort reset state", 32'({flags(1'b1), outs(1'b1)}), 32'({2'b00, 12'h000, 3'b011}));
        repeat (15) @(negedge clk);
        chk("no done after abort", 32'(done_cnt_s - base), 32'd0);
        chk("idle after abort", 32'(flags(1'b1)), 32'd0);
        conv(1'b1, 8'h63);
        conv(1'b1, 8'h80);

        repeat (3) @(negedge clk);
        chk("scoreboard drained s", 32'(q_s.size()), 32'd0);
        chk("scoreboard drained u", 32'(q_u.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
